// File: rtl/i2c_receptor_target.sv
// I2C target: matches a 7-bit address, then accepts a 2-byte write or returns a 2-byte read.
// scl/sda are oversampled on clk; the target drives sda only through sda_out/sda_oe.
module i2c_receptor_target #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  input  logic [ADDR_WIDTH-1:0] i2c_addr,
  input  logic [15:0]           rd_data,
  output logic                  sda_out,
  output logic                  sda_oe,
  output logic [15:0]           wr_data,
  output logic                  wr_valid,
  output logic                  rd_done,
  output logic                  busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_BYTE  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_BYTE  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]            state;
  logic [3:0]            bit_cnt;
  logic [1:0]            byte_idx;
  logic                  half;       // second half of a slot: the 9th/8th rise has been seen
  logic                  rnw;
  logic                  sda_drv;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [7:0]            rx_shift, wr_lo;
  logic [15:0]           rd_lat;
  logic [7:0]            rx_byte, rd_byte;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // START/STOP need scl steady high across the sda edge, so a coincident scl edge never counts
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign rx_byte = {rx_shift[6:0], sda_s};
  assign rd_byte = byte_idx[0] ? rd_lat[7:0] : rd_lat[15:8];
  assign sda_out = sda_oe & sda_drv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: synchronisers reset to the idle-bus level (1) so releasing reset never fakes an edge.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous stage's old value.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      half       <= 1'b0;
      rnw        <= 1'b0;
      sda_drv    <= 1'b0;
      sda_oe     <= 1'b0;
      addr_shift <= '0;
      rx_shift   <= '0;
      wr_lo      <= '0;
      rd_lat     <= '0;
      wr_data    <= '0;
      wr_valid   <= 1'b0;
      rd_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_done  <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        sda_drv <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'(ADDR_WIDTH);
        byte_idx <= '0;
        half     <= 1'b0;
        sda_oe   <= 1'b0;
        sda_drv  <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            if (bit_cnt != 4'd0) begin
              addr_shift <= {addr_shift[ADDR_WIDTH-2:0], sda_s};
              bit_cnt    <= bit_cnt - 4'd1;
            end else begin
              rnw <= sda_s;
              if (addr_shift == i2c_addr) begin
                state  <= ADDR_ACK;
                busy   <= 1'b1;
                rd_lat <= rd_data;
                half   <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise) half <= 1'b1;
            if (scl_fall && !half) begin
              sda_oe  <= 1'b1;
              sda_drv <= 1'b0;
            end else if (scl_fall) begin
              half     <= 1'b0;
              bit_cnt  <= 4'd7;
              byte_idx <= '0;
              state    <= rnw ? RD_BYTE : WR_BYTE;
              sda_oe   <= rnw;
              sda_drv  <= rnw & rd_lat[15];
            end
          end
          WR_BYTE: if (scl_rise) begin
            rx_shift <= rx_byte;
            if (bit_cnt != 4'd0) begin
              bit_cnt <= bit_cnt - 4'd1;
            end else if (byte_idx == 2'd2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WR_ACK;
              half  <= 1'b0;
              if (byte_idx == 2'd0) wr_lo <= rx_byte;
            end
          end
          WR_ACK: begin
            if (scl_rise) half <= 1'b1;
            if (scl_fall && !half) begin
              sda_oe  <= 1'b1;
              sda_drv <= 1'b0;
            end else if (scl_fall) begin
              sda_oe   <= 1'b0;
              half     <= 1'b0;
              state    <= WR_BYTE;
              bit_cnt  <= 4'd7;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd1) begin
                wr_data  <= {rx_shift, wr_lo};
                wr_valid <= 1'b1;
              end
            end
          end
          RD_BYTE: begin
            if (scl_rise && bit_cnt == 4'd0) half <= 1'b1;
            if (scl_fall && half) begin
              sda_oe  <= 1'b0;
              sda_drv <= 1'b0;
              half    <= 1'b0;
              state   <= RD_ACK;
            end else if (scl_fall) begin
              bit_cnt <= bit_cnt - 4'd1;
              sda_drv <= rd_byte[3'(bit_cnt - 4'd1)];
            end
          end
          RD_ACK: begin
            if (scl_rise && !half) begin
              if (byte_idx == 2'd1) begin
                rd_done <= 1'b1;
                state   <= IDLE;
                busy    <= 1'b0;
              end else if (!sda_s) begin
                byte_idx <= 2'd1;
                half     <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && half) begin
              sda_oe  <= 1'b1;
              sda_drv <= rd_lat[7];
              bit_cnt <= 4'd7;
              half    <= 1'b0;
              state   <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_receptor_target.sv
// Directed bench for i2c_receptor_target: a bit-banged generator drives scl/sda_in and
// checks acks, read data, write results and pulse counts against hand-computed values.
module tb_i2c_receptor_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        sda_in;
  logic [6:0]  i2c_addr;
  logic [15:0] rd_data;
  logic        sda_out, sda_oe, wr_valid, rd_done, busy;
  logic [15:0] wr_data;

  i2c_receptor_target #(.SYNC_STAGES(2), .ADDR_WIDTH(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .i2c_addr (i2c_addr),
    .rd_data  (rd_data),
    .sda_out  (sda_out),
    .sda_oe   (sda_oe),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_done  (rd_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  localparam int Q = 4;  // clk cycles per quarter scl period

  int vec_cnt = 0;
  int err_cnt = 0;
  int wv_cnt  = 0;
  int rd_cnt  = 0;
  int oe_cnt  = 0;
  int bad_cnt = 0;

  always @(posedge clk) begin
    if (wr_valid)          wv_cnt++;
    if (rd_done)           rd_cnt++;
    if (sda_oe)            oe_cnt++;
    if (!sda_oe && sda_out) bad_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic oe, output logic o);
    sda_in = b;
    wait_q();
    scl = 1'b1;
    wait_q();
    oe = sda_oe;
    o  = sda_out;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic start_cond();
    sda_in = 1'b1; wait_q();
    scl    = 1'b1; wait_q();
    sda_in = 1'b0; wait_q();
    scl    = 1'b0; wait_q();
  endtask

  task automatic stop_cond();
    sda_in = 1'b0; wait_q();
    scl    = 1'b1; wait_q();
    sda_in = 1'b1; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic oe, o;
    for (int i = 7; i >= 0; i--) clk_bit(v[i], oe, o);
  endtask

  task automatic ack_slot(input string tag, input logic exp_oe);
    logic oe, o;
    clk_bit(1'b1, oe, o);
    check(tag, 32'({oe, o}), 32'({exp_oe, 1'b0}));
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    logic oe, o;
    logic all_oe;
    logic [7:0] v;
    all_oe = 1'b1;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, oe, o);
      v[i]   = o;
      all_oe = all_oe & oe;
    end
    check(tag, 32'({all_oe, v}), 32'({1'b1, exp}));
  endtask

  task automatic master_ack(input string tag, input logic b);
    logic oe, o;
    clk_bit(b, oe, o);
    check(tag, 32'(oe), 32'd0);
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, sda_oe, sda_out, wr_valid, rd_done, busy, wr_data};
  endfunction

  int base_wv, base_rd, base_oe;

  initial begin
    reset = 1'b0; scl = 1'b1; sda_in = 1'b1;
    i2c_addr = 7'h5A; rd_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'd0);
    reset = 1'b1;
    wait_q();
    check("post_reset_outs", outs(), 32'd0);

    // Write 0x1234 to address 0x5A
    base_wv = wv_cnt;
    start_cond();
    send_byte(8'hB4);
    ack_slot("w_addr_ack", 1'b1);
    check("w_busy", 32'(busy), 32'd1);
    send_byte(8'h34);
    ack_slot("w_b0_ack", 1'b1);
    check("w_data_hold", 32'(wr_data), 32'd0);
    send_byte(8'h12);
    ack_slot("w_b1_ack", 1'b1);
    check("w_data", 32'(wr_data), 32'h1234);
    check("w_valid_pulses", 32'(wv_cnt - base_wv), 32'd1);
    stop_cond();
    wait_q();
    check("w_idle", 32'({busy, sda_oe}), 32'd0);

    // Read 0xA55A: generator acks byte 0, nacks byte 1
    rd_data = 16'hA55A;
    base_rd = rd_cnt;
    start_cond();
    send_byte(8'hB5);
    ack_slot("r_addr_ack", 1'b1);
    read_byte("r_byte0", 8'hA5);
    master_ack("r_mack0_released", 1'b0);
    read_byte("r_byte1", 8'h5A);
    master_ack("r_mnack1_released", 1'b1);
    check("r_done_pulses", 32'(rd_cnt - base_rd), 32'd1);
    stop_cond();
    wait_q();
    check("r_idle", 32'({busy, sda_oe}), 32'd0);

    // Address mismatch: 0x3C never acked, nothing driven
    base_oe = oe_cnt;
    base_wv = wv_cnt;
    start_cond();
    send_byte(8'h78);
    ack_slot("m_no_addr_ack", 1'b0);
    send_byte(8'h99);
    ack_slot("m_no_data_ack", 1'b0);
    stop_cond();
    wait_q();
    check("m_oe_never", 32'(oe_cnt - base_oe), 32'd0);
    check("m_wr_data", 32'(wr_data), 32'h1234);
    check("m_no_valid", 32'(wv_cnt - base_wv), 32'd0);

    // Early nack on read byte 0
    base_rd = rd_cnt;
    start_cond();
    send_byte(8'hB5);
    ack_slot("n_addr_ack", 1'b1);
    read_byte("n_byte0", 8'hA5);
    master_ack("n_nack_released", 1'b1);
    check("n_busy", 32'(busy), 32'd0);
    base_oe = oe_cnt;
    send_byte(8'hFF);
    check("n_stays_released", 32'(oe_cnt - base_oe), 32'd0);
    stop_cond();
    check("n_no_rd_done", 32'(rd_cnt - base_rd), 32'd0);

    // Repeated START after first write byte, then a full write and an extra byte
    base_wv = wv_cnt;
    start_cond();
    send_byte(8'hB4);
    ack_slot("rs_addr_ack0", 1'b1);
    send_byte(8'h77);
    ack_slot("rs_b0_ack", 1'b1);
    start_cond();
    send_byte(8'hB4);
    ack_slot("rs_addr_ack1", 1'b1);
    check("rs_data_kept", 32'(wr_data), 32'h1234);
    check("rs_no_valid", 32'(wv_cnt - base_wv), 32'd0);
    send_byte(8'hCD);
    ack_slot("rs_b0b_ack", 1'b1);
    send_byte(8'hAB);
    ack_slot("rs_b1b_ack", 1'b1);
    check("rs_data_new", 32'(wr_data), 32'hABCD);
    check("rs_one_valid", 32'(wv_cnt - base_wv), 32'd1);
    send_byte(8'hEE);
    ack_slot("rs_b2_nack", 1'b0);
    check("rs_data_after_b2", 32'(wr_data), 32'hABCD);
    stop_cond();
    wait_q();

    // Reset while the target drives the address ack
    start_cond();
    send_byte(8'hB4);
    sda_in = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    check("x_driving_ack", 32'({sda_oe, sda_out, busy}), 32'b101);
    reset = 1'b0;
    #1;
    check("x_immediate_release", outs(), 32'd0);
    scl = 1'b1; sda_in = 1'b1;
    wait_q();
    reset = 1'b1;
    wait_q();
    check("x_after_release", outs(), 32'd0);

    check("oe_gates_out", 32'(bad_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
